// File: rtl/rob_controller_pkg.sv
// Shared constants, forward-bus field positions and the ROB entry type
// used by the reorder-buffer controller and its commit selector.
package rob_controller_pkg;

    localparam int ROB_DEPTH = 64;
    localparam int ROB_IDX_W = 6;
    localparam int DATA_W    = 16;
    localparam int DEST_W    = 3;
    localparam int N_SLOTS   = 4;

    localparam int FWD_W      = 23;
    localparam int FWD_VALID  = 22;
    localparam int FWD_ROB_HI = 21;
    localparam int FWD_ROB_LO = 16;

    typedef struct packed {
        logic              valid;
        logic              ready;
        logic              wreg;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] value;
        logic [DATA_W-1:0] pc;
    } rob_entry_t;

    // Number of decode slots requesting this cycle (requests are contiguous from slot A).
    function automatic logic [2:0] req_count(input logic [N_SLOTS-1:0] req);
        logic [2:0] n;
        n = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            n = n + {2'b00, req[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Combinational retirement check on the two oldest ROB entries; produces the
// commit decision and the register-file write fields for both ports.
module rob_commit_sel
    import rob_controller_pkg::*;
(
    input  rob_entry_t        head_entry,
    input  rob_entry_t        next_entry,
    output logic              c0,
    output logic              c1,
    output logic [1:0]        n_commit,
    output logic              wen0,
    output logic              wen1,
    output logic [DEST_W-1:0] waddr0,
    output logic [DEST_W-1:0] waddr1,
    output logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] pc0,
    output logic [DATA_W-1:0] pc1
);

    // The second port may only retire behind the first, keeping program order.
    assign c0       = head_entry.valid & head_entry.ready;
    assign c1       = c0 & next_entry.valid & next_entry.ready;
    assign n_commit = {1'b0, c0} + {1'b0, c1};

    assign wen0   = c0 & head_entry.wreg;
    assign wen1   = c1 & next_entry.wreg;
    assign waddr0 = head_entry.dest;
    assign waddr1 = next_entry.dest;
    assign wdata0 = head_entry.value;
    assign wdata1 = next_entry.value;
    assign pc0    = head_entry.pc;
    assign pc1    = next_entry.pc;

endmodule

// File: rtl/rob_controller.sv
// 64-entry reorder-buffer controller: 4-wide in-order allocation, result capture
// from four forwarding buses, and 2-wide in-order retirement to the register file.
module rob_controller
    import rob_controller_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [N_SLOTS-1:0]          alloc_req,
    input  logic [N_SLOTS-1:0]          alloc_wreg,
    input  logic [N_SLOTS*DEST_W-1:0]   alloc_dest,
    input  logic [N_SLOTS*DATA_W-1:0]   alloc_pc,
    output logic                        alloc_ready,
    output logic [ROB_IDX_W-1:0]        alloc_base,
    input  logic [FWD_W-1:0]            forwardA,
    input  logic [FWD_W-1:0]            forwardB,
    input  logic [FWD_W-1:0]            forwardC,
    input  logic [FWD_W-1:0]            forwardD,
    output logic                        wen0,
    output logic                        wen1,
    output logic [DEST_W-1:0]           waddr0,
    output logic [DEST_W-1:0]           waddr1,
    output logic [DATA_W-1:0]           wdata0,
    output logic [DATA_W-1:0]           wdata1,
    output logic [1:0]                  commit_valid,
    output logic [ROB_IDX_W-1:0]        commit_idx0,
    output logic [ROB_IDX_W-1:0]        commit_idx1,
    output logic [DATA_W-1:0]           commit_pc0,
    output logic [DATA_W-1:0]           commit_pc1,
    output logic [ROB_IDX_W:0]          count
);

    localparam int DEPTH = ROB_DEPTH;
    localparam int IDX_W = ROB_IDX_W;
    localparam int CNT_W = IDX_W + 1;

    logic [IDX_W-1:0]  head_q;
    logic [IDX_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  ready_q;
    logic [DEPTH-1:0]  wreg_q;
    logic [DEST_W-1:0] dest_q  [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DATA_W-1:0] pc_q    [DEPTH];

    logic [FWD_W-1:0]  fwd      [N_SLOTS];
    logic [IDX_W-1:0]  fwd_idx  [N_SLOTS];
    logic [DATA_W-1:0] fwd_val  [N_SLOTS];
    logic [N_SLOTS-1:0] fwd_hit;

    logic [IDX_W-1:0]  slot_idx  [N_SLOTS];
    logic [DEST_W-1:0] slot_dest [N_SLOTS];
    logic [DATA_W-1:0] slot_pc   [N_SLOTS];

    logic              alloc_fire;
    logic [2:0]        n_alloc;
    logic [IDX_W-1:0]  head_nxt;

    rob_entry_t        head_entry;
    rob_entry_t        next_entry;
    logic              c0;
    logic              c1;
    logic [1:0]        n_commit;
    logic              sel_wen0;
    logic              sel_wen1;
    logic [DEST_W-1:0] sel_waddr0;
    logic [DEST_W-1:0] sel_waddr1;
    logic [DATA_W-1:0] sel_wdata0;
    logic [DATA_W-1:0] sel_wdata1;
    logic [DATA_W-1:0] sel_pc0;
    logic [DATA_W-1:0] sel_pc1;

    assign fwd[0] = forwardA;
    assign fwd[1] = forwardB;
    assign fwd[2] = forwardC;
    assign fwd[3] = forwardD;

    // A bus only counts when it targets a live entry; stale results are dropped.
    always_comb begin
        for (int b = 0; b < N_SLOTS; b++) begin
            fwd_idx[b] = fwd[b][FWD_ROB_HI:FWD_ROB_LO];
            fwd_val[b] = fwd[b][DATA_W-1:0];
            fwd_hit[b] = fwd[b][FWD_VALID] & valid_q[fwd_idx[b]];
        end
    end

    // Slot A is the most significant field of the packed dest/pc buses.
    always_comb begin
        for (int k = 0; k < N_SLOTS; k++) begin
            slot_idx[k]  = tail_q + IDX_W'(k);
            slot_dest[k] = alloc_dest[(N_SLOTS-1-k)*DEST_W +: DEST_W];
            slot_pc[k]   = alloc_pc[(N_SLOTS-1-k)*DATA_W +: DATA_W];
        end
    end

    assign alloc_ready = (count_q <= CNT_W'(DEPTH - N_SLOTS));
    assign alloc_base  = tail_q;
    assign alloc_fire  = alloc_ready & (|alloc_req);
    assign n_alloc     = alloc_fire ? req_count(alloc_req) : 3'd0;
    assign head_nxt    = head_q + IDX_W'(1);
    assign count       = count_q;

    // NOTE: every field of a combinational struct is assigned on every pass so no latch is inferred.
    always_comb begin
        head_entry       = '0;
        next_entry       = '0;
        head_entry.valid = valid_q[head_q];
        head_entry.ready = ready_q[head_q];
        head_entry.wreg  = wreg_q[head_q];
        head_entry.dest  = dest_q[head_q];
        head_entry.value = value_q[head_q];
        head_entry.pc    = pc_q[head_q];
        next_entry.valid = valid_q[head_nxt];
        next_entry.ready = ready_q[head_nxt];
        next_entry.wreg  = wreg_q[head_nxt];
        next_entry.dest  = dest_q[head_nxt];
        next_entry.value = value_q[head_nxt];
        next_entry.pc    = pc_q[head_nxt];
    end

    rob_commit_sel u_commit_sel (
        .head_entry (head_entry),
        .next_entry (next_entry),
        .c0         (c0),
        .c1         (c1),
        .n_commit   (n_commit),
        .wen0       (sel_wen0),
        .wen1       (sel_wen1),
        .waddr0     (sel_waddr0),
        .waddr1     (sel_waddr1),
        .wdata0     (sel_wdata0),
        .wdata1     (sel_wdata1),
        .pc0        (sel_pc0),
        .pc1        (sel_pc1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + IDX_W'(n_commit);
            tail_q  <= tail_q + IDX_W'(n_alloc);
            count_q <= count_q + CNT_W'(n_alloc) - CNT_W'(n_commit);
        end
    end

    // NOTE: non-blocking writes later in this block override earlier ones to the same bit,
    // so the statement order sets the priority forward < commit-clear < allocate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ready_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
            ready_q <= '0;
        end else begin
            for (int b = 0; b < N_SLOTS; b++) begin
                if (fwd_hit[b]) ready_q[fwd_idx[b]] <= 1'b1;
            end
            if (c0) begin
                valid_q[head_q] <= 1'b0;
                ready_q[head_q] <= 1'b0;
            end
            if (c1) begin
                valid_q[head_nxt] <= 1'b0;
                ready_q[head_nxt] <= 1'b0;
            end
            for (int k = 0; k < N_SLOTS; k++) begin
                if (alloc_fire && alloc_req[k]) begin
                    valid_q[slot_idx[k]] <= 1'b1;
                    ready_q[slot_idx[k]] <= 1'b0;
                end
            end
        end
    end

    // NOTE: payload storage has no reset; it is only observed through entries whose
    // valid/ready bits (reset above) qualify it.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int b = 0; b < N_SLOTS; b++) begin
                if (fwd_hit[b]) value_q[fwd_idx[b]] <= fwd_val[b];
            end
            for (int k = 0; k < N_SLOTS; k++) begin
                if (alloc_fire && alloc_req[k]) begin
                    wreg_q[slot_idx[k]] <= alloc_wreg[k];
                    dest_q[slot_idx[k]] <= slot_dest[k];
                    pc_q[slot_idx[k]]   <= slot_pc[k];
                end
            end
        end
    end

    // Port fields hold their last retired values while the port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid <= '0;
            commit_idx0  <= '0;
            commit_idx1  <= '0;
            commit_pc0   <= '0;
            commit_pc1   <= '0;
            wen0         <= 1'b0;
            wen1         <= 1'b0;
            waddr0       <= '0;
            waddr1       <= '0;
            wdata0       <= '0;
            wdata1       <= '0;
        end else if (flush) begin
            commit_valid <= '0;
            commit_idx0  <= '0;
            commit_idx1  <= '0;
            commit_pc0   <= '0;
            commit_pc1   <= '0;
            wen0         <= 1'b0;
            wen1         <= 1'b0;
            waddr0       <= '0;
            waddr1       <= '0;
            wdata0       <= '0;
            wdata1       <= '0;
        end else begin
            commit_valid <= {c1, c0};
            wen0         <= sel_wen0;
            wen1         <= sel_wen1;
            if (c0) begin
                commit_idx0 <= head_q;
                commit_pc0  <= sel_pc0;
                waddr0      <= sel_waddr0;
                wdata0      <= sel_wdata0;
            end
            if (c1) begin
                commit_idx1 <= head_nxt;
                commit_pc1  <= sel_pc1;
                waddr1      <= sel_waddr1;
                wdata1      <= sel_wdata1;
            end
        end
    end

endmodule

// File: tb/tb_rob_controller.sv
// Directed bench for rob_controller: allocations push expected retirements to a
// scoreboard queue that is popped and compared whenever a commit port fires.
module tb_rob_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [3:0]  alloc_req;
    logic [3:0]  alloc_wreg;
    logic [11:0] alloc_dest;
    logic [63:0] alloc_pc;
    logic        alloc_ready;
    logic [5:0]  alloc_base;
    logic [22:0] forwardA, forwardB, forwardC, forwardD;
    logic        wen0, wen1;
    logic [2:0]  waddr0, waddr1;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  commit_valid;
    logic [5:0]  commit_idx0, commit_idx1;
    logic [15:0] commit_pc0, commit_pc1;
    logic [6:0]  count;

    always #5 clk = ~clk;

    rob_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .alloc_req    (alloc_req),
        .alloc_wreg   (alloc_wreg),
        .alloc_dest   (alloc_dest),
        .alloc_pc     (alloc_pc),
        .alloc_ready  (alloc_ready),
        .alloc_base   (alloc_base),
        .forwardA     (forwardA),
        .forwardB     (forwardB),
        .forwardC     (forwardC),
        .forwardD     (forwardD),
        .wen0         (wen0),
        .wen1         (wen1),
        .waddr0       (waddr0),
        .waddr1       (waddr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .commit_valid (commit_valid),
        .commit_idx0  (commit_idx0),
        .commit_idx1  (commit_idx1),
        .commit_pc0   (commit_pc0),
        .commit_pc1   (commit_pc1),
        .count        (count)
    );

    typedef struct {
        logic [5:0]  idx;
        logic [15:0] pc;
        logic        wreg;
        logic [2:0]  dest;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] value_m [64];
    logic [5:0]  m_tail;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_port(input int p, input logic [5:0] idx, input logic [15:0] pc,
                           input logic wen, input logic [2:0] waddr, input logic [15:0] wdata);
        exp_t e;
        check($sformatf("sb_pending%0d", p), 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check($sformatf("commit_idx%0d", p), 32'(idx), 32'(e.idx));
            check($sformatf("commit_pc%0d", p), 32'(pc), 32'(e.pc));
            check($sformatf("wen%0d", p), 32'(wen), 32'(e.wreg));
            if (e.wreg) begin
                check($sformatf("waddr%0d", p), 32'(waddr), 32'(e.dest));
                check($sformatf("wdata%0d", p), 32'(wdata), 32'(value_m[e.idx]));
            end
        end
    endtask

    // Advance one clock, sample 1 time unit later and score any retirements.
    task automatic tick();
        @(posedge clk);
        #1;
        if (commit_valid[1]) check("commit_order", 32'(commit_valid[0]), 32'd1);
        if (commit_valid[0]) sb_port(0, commit_idx0, commit_pc0, wen0, waddr0, wdata0);
        else                 check("wen0_idle", 32'(wen0), 32'd0);
        if (commit_valid[1]) sb_port(1, commit_idx1, commit_pc1, wen1, waddr1, wdata1);
        else                 check("wen1_idle", 32'(wen1), 32'd0);
    endtask

    task automatic set_slots(input logic [3:0] req, input logic [3:0] wreg, input logic [15:0] pc0);
        alloc_req  = req;
        alloc_wreg = wreg;
        for (int k = 0; k < 4; k++) begin
            logic [5:0] t;
            t = m_tail + 6'(k);
            alloc_dest[(3-k)*3 +: 3]  = t[2:0];
            alloc_pc[(3-k)*16 +: 16] = pc0 + 16'(2*k);
        end
    endtask

    task automatic push_slots();
        int n;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (alloc_req[k]) begin
                exp_t e;
                e.idx  = m_tail + 6'(k);
                e.pc   = alloc_pc[(3-k)*16 +: 16];
                e.wreg = alloc_wreg[k];
                e.dest = alloc_dest[(3-k)*3 +: 3];
                sb_q.push_back(e);
                n++;
            end
        end
        m_tail = m_tail + 6'(n);
    endtask

    task automatic do_alloc(input logic [3:0] req, input logic [3:0] wreg, input logic [15:0] pc0);
        set_slots(req, wreg, pc0);
        push_slots();
        tick();
        alloc_req = '0;
    endtask

    task automatic set_fwd(input int b, input logic [5:0] idx, input logic [15:0] v);
        logic [22:0] w;
        w = {1'b1, idx, v};
        case (b)
            0:       forwardA = w;
            1:       forwardB = w;
            2:       forwardC = w;
            default: forwardD = w;
        endcase
        value_m[idx] = v;
    endtask

    task automatic clear_fwd();
        forwardA = '0;
        forwardB = '0;
        forwardC = '0;
        forwardD = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        alloc_req = '0; alloc_wreg = '0; alloc_dest = '0; alloc_pc = '0;
        clear_fwd();
        m_tail = '0;
        for (int i = 0; i < 64; i++) value_m[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_alloc_base", 32'(alloc_base), 32'd0);
        check("rst_commit_valid", 32'(commit_valid), 32'd0);
        check("rst_wen", 32'({wen0, wen1}), 32'd0);
        rst_n = 1'b1;

        // Four-wide allocation, PCs 0,2,4,6
        do_alloc(4'b1111, 4'b1111, 16'h0000);
        check("alloc4_count", 32'(count), 32'd4);
        check("alloc4_base", 32'(alloc_base), 32'd4);
        check("alloc4_no_commit", 32'(commit_valid), 32'd0);

        // Younger entry ready first must not retire
        set_fwd(1, 6'd1, 16'h00AA);
        tick();
        clear_fwd();
        tick();
        check("young_ready_no_commit", 32'(commit_valid), 32'd0);

        // Head becomes ready: two-port retirement two cycles after the forward
        set_fwd(0, 6'd0, 16'h0005);
        tick();
        clear_fwd();
        check("fwd_no_bypass", 32'(commit_valid), 32'd0);
        tick();
        check("dual_commit_valid", 32'(commit_valid), 32'd3);
        check("dual_wdata0", 32'(wdata0), 32'h0005);
        check("dual_wdata1", 32'(wdata1), 32'h00AA);
        check("dual_idx1", 32'(commit_idx1), 32'd1);
        check("dual_count", 32'(count), 32'd2);

        // Fill to 61 entries
        for (int i = 0; i < 14; i++) do_alloc(4'b1111, 4'b0101, 16'h0100 + 16'(8*i));
        check("fill58_ready", 32'(alloc_ready), 32'd1);
        do_alloc(4'b0111, 4'b0110, 16'h0200);
        check("fill61_count", 32'(count), 32'd61);
        check("fill61_not_ready", 32'(alloc_ready), 32'd0);
        check("fill61_base", 32'(alloc_base), 32'd63);

        // Requests while not ready are ignored
        set_slots(4'b1111, 4'b1111, 16'h0F00);
        tick();
        alloc_req = '0;
        check("ignored_count", 32'(count), 32'd61);
        check("ignored_base", 32'(alloc_base), 32'd63);

        // Held request: commit in the same cycle does not free space until the next
        set_slots(4'b0001, 4'b0001, 16'h1000);
        set_fwd(0, 6'd2, 16'h0222);
        tick();
        clear_fwd();
        check("held_count_a", 32'(count), 32'd61);
        tick();
        check("held_commit", 32'(commit_valid), 32'd1);
        check("held_count_b", 32'(count), 32'd60);
        check("held_ready", 32'(alloc_ready), 32'd1);
        push_slots();
        tick();
        alloc_req = '0;
        check("held_accept_count", 32'(count), 32'd61);
        check("tail_wrap_base", 32'(alloc_base), 32'd0);

        // Make entries 3..62 ready four per cycle while retirement drains them
        for (int c = 0; c < 15; c++) begin
            for (int b = 0; b < 4; b++) set_fwd(b, 6'(3 + 4*c + b), 16'h3000 + 16'(4*c + b));
            tick();
        end
        clear_fwd();
        do_alloc(4'b1111, 4'b1100, 16'h2000);
        for (int b = 0; b < 4; b++) set_fwd(b, 6'(b), 16'h4000 + 16'(b));
        tick();
        clear_fwd();
        for (int i = 0; i < 64 && count != 7'd5; i++) tick();
        check("drain_count", 32'(count), 32'd5);
        tick();
        check("stall_on_63", 32'(commit_valid), 32'd0);

        // Same index on buses A and C: C wins; retirement wraps 63 -> 0
        set_fwd(0, 6'd63, 16'h1111);
        set_fwd(2, 6'd63, 16'h2222);
        tick();
        clear_fwd();
        check("wrap_no_bypass", 32'(commit_valid), 32'd0);
        tick();
        check("wrap_valid", 32'(commit_valid), 32'd3);
        check("wrap_idx0", 32'(commit_idx0), 32'd63);
        check("wrap_idx1", 32'(commit_idx1), 32'd0);
        check("later_bus_wins", 32'(wdata0), 32'h2222);
        check("nowreg_wen1", 32'(wen1), 32'd0);
        tick();
        check("nowreg_valid", 32'(commit_valid), 32'd3);
        check("nowreg_idx0", 32'(commit_idx0), 32'd1);
        check("nowreg_wen0", 32'(wen0), 32'd0);
        tick();
        check("single_valid", 32'(commit_valid), 32'd1);
        check("single_idx0", 32'(commit_idx0), 32'd3);
        check("empty_count", 32'(count), 32'd0);

        // Forward to an invalid entry is dropped
        set_fwd(0, 6'd4, 16'hBEEF);
        tick();
        clear_fwd();
        do_alloc(4'b0001, 4'b0001, 16'h5000);
        tick();
        tick();
        check("stale_fwd_no_commit", 32'(commit_valid), 32'd0);
        check("stale_fwd_count", 32'(count), 32'd1);

        // Flush with count 8 and a same-cycle forward
        do_alloc(4'b0111, 4'b1111, 16'h6000);
        do_alloc(4'b1111, 4'b1111, 16'h7000);
        check("preflush_count", 32'(count), 32'd8);
        set_fwd(0, 6'd4, 16'h1234);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_fwd();
        sb_q.delete();
        m_tail = '0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_base", 32'(alloc_base), 32'd0);
        check("flush_commit_valid", 32'(commit_valid), 32'd0);
        check("flush_wen", 32'({wen0, wen1}), 32'd0);
        tick();
        check("postflush_commit_valid", 32'(commit_valid), 32'd0);
        check("postflush_count", 32'(count), 32'd0);

        // Asynchronous reset while commit outputs are active
        do_alloc(4'b0011, 4'b0011, 16'h8000);
        set_fwd(0, 6'd0, 16'h00C0);
        set_fwd(1, 6'd1, 16'h00C1);
        tick();
        clear_fwd();
        tick();
        check("prereset_commit", 32'(commit_valid), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_commit_valid", 32'(commit_valid), 32'd0);
        check("async_rst_wen", 32'({wen0, wen1}), 32'd0);
        check("async_rst_wdata0", 32'(wdata0), 32'd0);
        check("async_rst_idx1", 32'(commit_idx1), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        #3;
        rst_n = 1'b1;
        sb_q.delete();
        m_tail = '0;
        tick();
        check("postrst_ready", 32'(alloc_ready), 32'd1);
        check("postrst_base", 32'(alloc_base), 32'd0);
        check("postrst_commit_valid", 32'(commit_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
